fifo_wr_ptr: RTL
================

# fifo_wr_ptr

Write-side pointer and flag generator for the asynchronous FIFO. Holds the binary write pointer and converts it to a registered Gray-coded copy for safe crossing into the read domain. Synchronises the read side's Gray pointer into the write clock and derives `full`, `almost_full`, fill level and overflow from it. Sits beside the dual-port RAM in the write clock domain and is the counterpart of the read-side pointer logic, which decodes the Gray pointers this block produces.

## Interface
- `ADDR_WIDTH`, 4: RAM address bits; depth = 2^ADDR_WIDTH; must be >= 2.
- `SYNC_STAGES`, 2: flop stages on the incoming read pointer; must be >= 2.
- `AF_THRESH`, 14: `almost_full` asserts when level >= AF_THRESH; range 1..depth.

- `clk`  in  1  write-domain clock; the block's only clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `wr_en`  in  1  write request from the producer.
- `rd_gray_async`  in  ADDR_WIDTH+1  read pointer, Gray-coded, from the read domain, asynchronous to `clk`.
- `wr_accept`  out  1  combinational `wr_en & ~full`; RAM write enable.
- `wr_addr`  out  ADDR_WIDTH  RAM write address = low bits of binary write pointer.
- `wr_gray`  out  ADDR_WIDTH+1  registered Gray write pointer, to the read domain.
- `full`  out  1  registered.
- `almost_full`  out  1  registered.
- `wr_level`  out  ADDR_WIDTH+1  registered occupancy as seen by the write side, 0..depth.
- `overflow`  out  1  registered one-cycle pulse, write attempted while full.

## Operation
- Binary pointer `wbin`, ADDR_WIDTH+1 bits, increments by 1 mod 2^(ADDR_WIDTH+1) on each `wr_accept`. `wbin_next = wbin + wr_accept`.
- `wr_gray <= wbin_next ^ (wbin_next >> 1)`. It changes at most one bit per edge and is driven only from a flop, with no logic after it.
- Synchroniser: `rd_gray_async` passes through SYNC_STAGES flops to give `rsync_gray`. `rbin` is the Gray-to-binary decode of `rsync_gray`: MSB passes through, and each lower bit is the XOR of its Gray bit with the next higher decoded bit.
- `full <= (bin_to_gray(wbin_next) == {~rsync_gray[A:A-1], rsync_gray[A-2:0]})`, where A = ADDR_WIDTH.
- `wr_level <= wbin_next - rbin` (mod 2^(A+1)). Never exceeds depth.
- `almost_full <= (wbin_next - rbin) >= AF_THRESH`.
- `overflow <= wr_en & full`. On overflow, the pointer, address and Gray output do not change.
- Reset (`rst_n` low at an edge): `wbin`, `wr_gray`, all synchroniser flops, `full`, `almost_full`, `wr_level` and `overflow` all go to 0. `wr_accept` = `wr_en`. Reset during a write discards that write. The read domain is reset by its own logic.
- There is no explicit state machine. The state is `wbin`, the synchroniser chain and the flag registers.

## Timing
- Write accepted at edge N: `wr_addr` and `wr_gray` show the new pointer after N; `full`, `wr_level` and `almost_full` reflect it after the same edge N (zero added latency, because they are computed from `wbin_next`).
- Write that fills the last slot: `full` is high in the very next cycle, so a back-to-back write is refused and no overrun occurs.
- Read pointer change at the `rd_gray_async` pins: `rsync_gray` updates after SYNC_STAGES edges. `full`, `level` and `almost_full` update one edge later, giving a total of SYNC_STAGES+1 cycles (3 by default). Flags are therefore pessimistic, never optimistic.
- Simultaneous write and sync update in one cycle: both apply. `wr_level` = old level + 1 − reads now visible.
- Wrap: `wbin` goes from 31 to 0 (default); `wr_addr` goes from 15 to 0; `wr_gray` goes from 10000 to 00000 (single bit change).

## Structure
- Shared package `fifo_pkg`: `bin_to_gray` function and pointer width localparam `PTR_W = ADDR_WIDTH+1`. The package is shared with the read-side pointer block.
- Sub-module: the existing `gray_to_bin` (WIDTH = PTR_W) decodes `rsync_gray`. The synchroniser chain is a separate `sync_ff` sub-module, parameterised by width and stages.

## Test plan
- Reset, then 16 writes with `rd_gray_async` = 0 → `wr_addr` goes 0..15. `almost_full` rises after the 14th write. `full` rises after the 16th write. `wr_level` = 16.
- 17th write while full → `wr_accept` = 0, `overflow` pulses for 1 cycle, `wr_gray` stays at 11000.
- From full, set `rd_gray_async` = 00001 (1 read) → `full` drops and `wr_level` = 15 exactly 3 cycles later.
- Stream 40 writes with the read pointer trailing by 4 → `wr_gray` Hamming distance is 1 at every change. The pointer wraps 31→0 with no false `full`.
- Write and read-pointer update in the same cycle at level 8 → level = 8 after the sync latency. There is no glitch on `full`.
- Assert `rst_n` low mid-burst while full, for 1 cycle → all outputs 0 on the next cycle. The write in that cycle is dropped. `overflow` stays 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared pointer definitions for the write- and read-side pointer blocks of the async FIFO.
package fifo_pkg;

  localparam int unsigned FIFO_ADDR_W = 4;
  localparam int unsigned PTR_W       = FIFO_ADDR_W + 1;

  // Binary to reflected Gray code; callers cast to their pointer width.
  function automatic logic [31:0] bin_to_gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decoder.
module gray_to_bin
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = PTR_W
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/sync_ff.sv
// Multi-stage flop synchroniser for a Gray-coded bus crossing into clk.
module sync_ff #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        chain[i] <= '0;
      end
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/fifo_wr_ptr.sv
// Async FIFO write-side pointer: binary/Gray write pointer, read-pointer sync, full/level flags.
module fifo_wr_ptr
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = FIFO_ADDR_W,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AF_THRESH   = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   rd_gray_async,
  output logic                  wr_accept,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   wr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  overflow
);

  localparam int unsigned A  = ADDR_WIDTH;
  localparam int unsigned PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] rsync_gray;
  logic [PW-1:0] rbin;
  logic [PW-1:0] full_cmp;
  logic [PW-1:0] level_next;

  sync_ff #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_rd_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rd_gray_async),
    .q     (rsync_gray)
  );

  gray_to_bin #(
    .WIDTH (PW)
  ) u_rd_dec (
    .gray (rsync_gray),
    .bin  (rbin)
  );

  assign wr_accept  = wr_en & ~full;
  assign wbin_next  = wbin + PW'(wr_accept);
  assign gray_next  = PW'(bin_to_gray(32'(wbin_next)));
  assign level_next = wbin_next - rbin;
  assign wr_addr    = wbin[A-1:0];

  // Full when the write pointer is exactly one lap ahead of the synchronised read pointer.
  assign full_cmp = {~rsync_gray[A:A-1], rsync_gray[A-2:0]};

  // Flags are computed from wbin_next so an accepted write is reflected after the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wbin        <= '0;
      wr_gray     <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      overflow    <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wr_gray     <= gray_next;
      full        <= (gray_next == full_cmp);
      almost_full <= (level_next >= PW'(AF_THRESH));
      wr_level    <= level_next;
      overflow    <= wr_en & full;
    end
  end

endmodule
